// File: rtl/mem_responder_pkg.sv
// Shared constants and the address-to-word-index helper for mem_responder.
package mem_responder_pkg;

  localparam int unsigned LATENCY_DEF     = 1;
  localparam int unsigned DEPTH_WORDS_DEF = 4096;
  localparam logic [31:0] BASE_ADDR_DEF   = 32'h0000_0000;
  localparam int unsigned LATENCY_MAX     = 8;
  localparam int unsigned OUTST_W         = 4;

  // Byte offset below the word boundary is shifted away, never rounded.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input int unsigned off_bits);
    return (addr - base) >> off_bits;
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-length response delay line: {valid, err, data} advances one stage every cycle.
module mem_resp_pipe
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_valid,
  input  logic              i_err,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic              o_err,
  output logic [DATA_W-1:0] o_data
);

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] data;
  } stage_t;

  stage_t r_stage [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample its predecessor's old value, so the line shifts instead of collapsing.
      r_stage[0] <= {i_valid, i_err, i_data};
      for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_valid = r_stage[LATENCY-1].valid;
  assign o_err   = r_stage[LATENCY-1].err;
  assign o_data  = r_stage[LATENCY-1].data;

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder with fixed-latency in-order responses.
// Optional out-of-range detection enabled by defining MEM_RESPONDER_RANGE_CHECK_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned MEM_W       = 32,
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned LATENCY     = LATENCY_DEF,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mem_req_i,
  input  logic [31:0]          mem_addr_i,
  input  logic                 mem_we_i,
  input  logic [MEM_W/8-1:0]   mem_be_i,
  input  logic [MEM_W-1:0]     mem_wdata_i,
  output logic                 mem_rvalid_o,
  output logic                 mem_err_o,
  output logic [MEM_W-1:0]     mem_rdata_o,
  output logic [OUTST_W-1:0]   mem_outstanding_o
);

  localparam int unsigned BE_W     = MEM_W / 8;
  localparam int unsigned OFF_BITS = $clog2(BE_W);
  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);

  logic [MEM_W-1:0]   r_mem [DEPTH_WORDS];
  logic [OUTST_W-1:0] r_outstanding;

  logic [IDX_W-1:0]   w_idx;
  logic               w_in_range;
  logic               w_rsp_err;
  logic               w_wr_en;
  logic [MEM_W-1:0]   w_rsp_data;

  // Truncating the index to IDX_W bits is what makes addresses wrap modulo the depth.
  assign w_idx = IDX_W'(word_index(mem_addr_i, BASE_ADDR, OFF_BITS));

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'(BE_W);
  logic [32:0] w_diff;

  // A borrow out of the 33-bit subtraction (below base) also lands above SPAN_BYTES.
  assign w_diff     = {1'b0, mem_addr_i} - {1'b0, BASE_ADDR};
  assign w_in_range = (w_diff < SPAN_BYTES);
  assign w_rsp_err  = mem_req_i && !w_in_range;
`else
  assign w_in_range = 1'b1;
  assign w_rsp_err  = 1'b0;
`endif

  assign w_wr_en    = mem_req_i && mem_we_i && w_in_range;
  assign w_rsp_data = (mem_req_i && !mem_we_i && w_in_range) ? r_mem[w_idx] : '0;

  // NOTE: the storage array deliberately has no reset; clearing it would force flops instead of RAM.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (mem_be_i[b]) r_mem[w_idx][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
      end
    end
  end

  mem_resp_pipe #(
    .DATA_W  (MEM_W),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_valid (mem_req_i),
    .i_err   (w_rsp_err),
    .i_data  (w_rsp_data),
    .o_valid (mem_rvalid_o),
    .o_err   (mem_err_o),
    .o_data  (mem_rdata_o)
  );

  // Acceptance and response in the same cycle cancel, so the count holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
    end else if (mem_req_i && !mem_rvalid_o) begin
      r_outstanding <= r_outstanding + OUTST_W'(1);
    end else if (!mem_req_i && mem_rvalid_o) begin
      r_outstanding <= r_outstanding - OUTST_W'(1);
    end
  end

  assign mem_outstanding_o = r_outstanding;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 1, 3, 4) share one stimulus stream
// and are compared each cycle against a history-based model; honours MEM_RESPONDER_RANGE_CHECK_EN.
module tb_mem_responder;

  localparam int unsigned DEPTH = 4096;
  localparam int          HMAX  = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;

  logic [2:0]       rv;
  logic [2:0]       er;
  logic [2:0][31:0] rd;
  logic [2:0][3:0]  outs;

  always #5 clk = ~clk;

  mem_responder #(.MEM_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut_l1 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_addr_i(addr), .mem_we_i(we),
    .mem_be_i(be), .mem_wdata_i(wdata), .mem_rvalid_o(rv[0]), .mem_err_o(er[0]),
    .mem_rdata_o(rd[0]), .mem_outstanding_o(outs[0]));

  mem_responder #(.MEM_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(3), .BASE_ADDR(32'h0)) u_dut_l3 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_addr_i(addr), .mem_we_i(we),
    .mem_be_i(be), .mem_wdata_i(wdata), .mem_rvalid_o(rv[1]), .mem_err_o(er[1]),
    .mem_rdata_o(rd[1]), .mem_outstanding_o(outs[1]));

  mem_responder #(.MEM_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(4), .BASE_ADDR(32'h0)) u_dut_l4 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_addr_i(addr), .mem_we_i(we),
    .mem_be_i(be), .mem_wdata_i(wdata), .mem_rvalid_o(rv[2]), .mem_err_o(er[2]),
    .mem_rdata_o(rd[2]), .mem_outstanding_o(outs[2]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int flush_upto = 0;

  // Expected response of the request accepted at edge n, and the model storage.
  logic        h_v [HMAX];
  logic        h_e [HMAX];
  logic [31:0] h_d [HMAX];
  logic [31:0] mdl_mem [DEPTH];

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int idx;
    cyc = cyc + 1;
    h_v[cyc] = 1'b0;
    h_e[cyc] = 1'b0;
    h_d[cyc] = '0;
    if (rst_n && req) begin
      idx = int'((addr >> 2) % DEPTH);
      h_v[cyc] = 1'b1;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
      if (addr >= DEPTH * 4) begin
        h_e[cyc] = 1'b1;
      end else
`endif
      if (!we) begin
        h_d[cyc] = mdl_mem[idx];
      end else begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  // A response visible now belongs to the request accepted LATENCY-1 edges ago.
  function automatic logic [33:0] exp_rsp(input int k);
    int n;
    n = cyc - lat_of(k) + 1;
    if (n < 1 || n <= flush_upto) return '0;
    return {h_v[n], h_e[n], h_d[n]};
  endfunction

  function automatic logic [3:0] exp_out(input int k);
    int cnt;
    cnt = 0;
    for (int n = cyc - lat_of(k) + 1; n <= cyc; n++)
      if (n >= 1 && n > flush_upto && h_v[n]) cnt++;
    return 4'(cnt);
  endfunction

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req = r; we = w; addr = a; be = b; wdata = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      req = 1'b1; we = 1'b0; addr = 32'h40;
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rv[k] !== 1'b0 || er[k] !== 1'b0 || rd[k] !== '0 || outs[k] !== '0) begin
          errors++;
          $display("FAIL reset_outputs L%0d: got v%0b e%0b d%08h o%0d, want all zero",
                   lat_of(k), rv[k], er[k], rd[k], outs[k]);
        end
      end
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 32'h0, 4'hF, 32'h0BAD_F00D);
    checks++;
    if (rv[0] !== 1'b1 || outs[0] !== 4'd1) begin
      errors++;
      $display("FAIL first_after_reset: got v%0b o%0d, want v1 o1", rv[0], outs[0]);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 259; i++) begin
      if (i < 256) drive(1'b1, 1'b1, 32'(i * 4), 4'hF, $urandom);
      else         drive(1'b0, 1'b0, '0, '0, '0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({rv[k], er[k], rd[k]} !== exp_rsp(k) || outs[k] !== exp_out(k)) begin
          errors++;
          $display("FAIL fill L%0d cyc %0d: got v%0b e%0b d%08h o%0d, want %09h o%0d",
                   lat_of(k), cyc, rv[k], er[k], rd[k], outs[k], exp_rsp(k), exp_out(k));
        end
      end
    end
  endtask

  task automatic test_directed();
    logic        s_we [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] s_a  [7] = '{32'h100, 32'h100, 32'h104, 32'h104, 32'h106, 32'h0, 32'h0};
    logic [3:0]  s_be [7] = '{4'hF, 4'h0, 4'hF, 4'b0010, 4'h0, 4'h0, 4'h0};
    logic [31:0] s_d  [7] = '{32'hDEAD_BEEF, 32'h0, 32'h1122_3344, 32'h0000_AB00, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 11; i++) begin
      if (i < 5) drive(1'b1, s_we[i], s_a[i], s_be[i], s_d[i]);
      else       drive(1'b0, 1'b0, '0, '0, '0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({rv[k], er[k], rd[k]} !== exp_rsp(k) || outs[k] !== exp_out(k)) begin
          errors++;
          $display("FAIL directed L%0d cyc %0d: got v%0b e%0b d%08h o%0d, want %09h o%0d",
                   lat_of(k), cyc, rv[k], er[k], rd[k], outs[k], exp_rsp(k), exp_out(k));
        end
      end
      if (i == 0 || i == 1 || i == 4) begin
        checks++;
        if (rv[0] !== 1'b1 || er[0] !== 1'b0 ||
            rd[0] !== (i == 0 ? 32'h0 : (i == 1 ? 32'hDEAD_BEEF : 32'h1122_AB44))) begin
          errors++;
          $display("FAIL directed_l1 step %0d: got v%0b e%0b d%08h", i, rv[0], er[0], rd[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n0, first, ones, last, peak;
    logic [31:0] got [$];
    first = -1; ones = 0; last = -1; peak = 0;
    n0 = cyc + 1;
    for (int i = 0; i < 16; i++) begin
      if (i < 10) drive(1'b1, 1'b0, 32'h200 + 32'(i * 4), 4'h0, '0);
      else        drive(1'b0, 1'b0, '0, '0, '0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({rv[k], er[k], rd[k]} !== exp_rsp(k) || outs[k] !== exp_out(k)) begin
          errors++;
          $display("FAIL b2b L%0d cyc %0d: got v%0b e%0b d%08h o%0d, want %09h o%0d",
                   lat_of(k), cyc, rv[k], er[k], rd[k], outs[k], exp_rsp(k), exp_out(k));
        end
      end
      if (int'(outs[2]) > peak) peak = int'(outs[2]);
      if (rv[2] === 1'b1) begin
        if (first < 0) first = cyc + 1;
        last = cyc + 1;
        ones++;
        got.push_back(rd[2]);
      end
    end
    checks++;
    if (first !== n0 + 4 || ones !== 10 || last - first !== 9) begin
      errors++;
      $display("FAIL b2b_timing: got first %0d count %0d span %0d, want first %0d count 10 span 9",
               first, ones, last - first, n0 + 4);
    end
    checks++;
    if (peak !== 4) begin
      errors++;
      $display("FAIL b2b_peak_outstanding: got %0d, want 4", peak);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== mdl_mem[128 + i]) begin
        errors++;
        $display("FAIL b2b_order idx %0d: got %08h, want %08h", i,
                 (i < got.size()) ? got[i] : 32'hx, mdl_mem[128 + i]);
      end
    end
  endtask

  task automatic test_reset_flush();
    int l3_seen;
    l3_seen = 0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h10 + 32'(i * 4), 4'h0, '0);
      if (rv[1] === 1'b1) l3_seen++;
    end
    // Third request meets reset in the same cycle, before any LATENCY=3 response is due.
    req = 1'b1; we = 1'b0; addr = 32'h18;
    rst_n = 1'b0;
    flush_upto = cyc;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rv[k] !== 1'b0 || er[k] !== 1'b0 || rd[k] !== '0 || outs[k] !== '0) begin
        errors++;
        $display("FAIL flush_in_reset L%0d: got v%0b e%0b d%08h o%0d, want all zero",
                 lat_of(k), rv[k], er[k], rd[k], outs[k]);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, '0, '0, '0);
      if (rv[1] === 1'b1) l3_seen++;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({rv[k], er[k], rd[k]} !== exp_rsp(k) || outs[k] !== exp_out(k)) begin
          errors++;
          $display("FAIL flush L%0d cyc %0d: got v%0b e%0b d%08h o%0d, want %09h o%0d",
                   lat_of(k), cyc, rv[k], er[k], rd[k], outs[k], exp_rsp(k), exp_out(k));
        end
      end
    end
    checks++;
    if (l3_seen !== 0 || outs[1] !== 4'd0) begin
      errors++;
      $display("FAIL flush_l3: got %0d responses o%0d, want 0 responses o0", l3_seen, outs[1]);
    end
  endtask

  task automatic test_range();
    logic [31:0] w0;
    w0 = mdl_mem[0];
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       drive(1'b1, 1'b1, 32'h4000, 4'hF, 32'hCAFE_F00D);
        1:       drive(1'b1, 1'b0, 32'h4000, 4'h0, '0);
        2:       drive(1'b1, 1'b0, 32'h0, 4'h0, '0);
        default: drive(1'b0, 1'b0, '0, '0, '0);
      endcase
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({rv[k], er[k], rd[k]} !== exp_rsp(k) || outs[k] !== exp_out(k)) begin
          errors++;
          $display("FAIL range L%0d cyc %0d: got v%0b e%0b d%08h o%0d, want %09h o%0d",
                   lat_of(k), cyc, rv[k], er[k], rd[k], outs[k], exp_rsp(k), exp_out(k));
        end
      end
      if (i < 3) begin
        checks++;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        if (rv[0] !== 1'b1 || er[0] !== (i < 2) || rd[0] !== (i == 2 ? w0 : 32'h0)) begin
          errors++;
          $display("FAIL range_l1 step %0d: got v%0b e%0b d%08h, word0 was %08h",
                   i, rv[0], er[0], rd[0], w0);
        end
`else
        if (rv[0] !== 1'b1 || er[0] !== 1'b0 || rd[0] !== (i == 0 ? 32'h0 : 32'hCAFE_F00D)) begin
          errors++;
          $display("FAIL alias_l1 step %0d: got v%0b e%0b d%08h, word0 was %08h",
                   i, rv[0], er[0], rd[0], w0);
        end
`endif
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 305; i++) begin
      a = ($urandom_range(0, 15) == 0) ? 32'h4000 + $urandom_range(0, 32'h3FF)
                                       : $urandom_range(0, 32'h3FF);
      if (i < 300) drive($urandom_range(0, 3) != 0, 1'($urandom), a, 4'($urandom), $urandom);
      else         drive(1'b0, 1'b0, '0, '0, '0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({rv[k], er[k], rd[k]} !== exp_rsp(k) || outs[k] !== exp_out(k)) begin
          errors++;
          $display("FAIL random L%0d cyc %0d: got v%0b e%0b d%08h o%0d, want %09h o%0d",
                   lat_of(k), cyc, rv[k], er[k], rd[k], outs[k], exp_rsp(k), exp_out(k));
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    test_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
